// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory controller.
package dmem_pkg;

  // Controller FSM, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Access size codes (2'b11 behaves as a word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_TIMEOUT = 255;

  // One memory access as seen by the controller; latched whole in IDLE
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic        we;
    logic [31:0] wd;
  } memReq_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane formatting: store replication/strobes, load extraction/extension,
// and misalignment detection. Purely combinational.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic        isWrite,
  input  logic [31:0] wd,
  input  logic [31:0] rdRaw,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] rdFmt,
  output logic        misaligned
);

  logic [3:0] strbRaw;
  logic [7:0] byteSel;
  logic [15:0] halfSel;

  // Store side: replicate data across lanes, strobe only the addressed bytes
  always_comb begin
    strbRaw = 4'b1111;
    wdata   = wd;
    case (size)
      SZ_BYTE: begin
        strbRaw = 4'b0001 << addrLo;
        wdata   = {4{wd[7:0]}};
      end
      SZ_HALF: begin
        strbRaw = addrLo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{wd[15:0]}};
      end
      default: begin
        strbRaw = 4'b1111;
        wdata   = wd;
      end
    endcase
    wstrb = isWrite ? strbRaw : 4'b0000;
  end

  assign byteSel = rdRaw[{addrLo, 3'b000} +: 8];
  assign halfSel = addrLo[1] ? rdRaw[31:16] : rdRaw[15:0];

  // Load side: pick the lane and sign/zero-extend; words pass straight through
  always_comb begin
    case (size)
      SZ_BYTE: rdFmt = {{24{sext & byteSel[7]}}, byteSel};
      SZ_HALF: rdFmt = {{16{sext & halfSel[15]}}, halfSel};
      default: rdFmt = rdRaw;
    endcase
  end

  // Halves need even addresses, words (and size 11) need word alignment
  always_comb begin
    misaligned = 1'b0;
    if (size == SZ_HALF) misaligned = addrLo[0];
    else if (size[1])    misaligned = (addrLo != 2'b00);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: req/ready + rvalid bus handshake, pipeline
// stall while an access is outstanding, timeout abort with bus_err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8            // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_signedM,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] writedataM,
  output logic [31:0] mem_rdata,
  output logic        stallM,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, stateNxt;
  memReq_t          req, mReq, cur;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdataQ;
  logic             errQ;
  logic             mAcc, start, misal;
  logic             busReqC, stallC, capture, timeout, cntClr;
  logic [31:0]      fmtWdata, fmtRdata;
  logic [3:0]       fmtStrb;

  // Reset gates the M-side request so every output is 0 while rst is low
  assign mAcc  = rst & (memreadM | memwriteM);
  assign mReq  = '{addr: alu_resultM, size: mem_sizeM, sext: mem_signedM,
                   we: memwriteM, wd: writedataM};
  // In IDLE the bus is driven straight from the M inputs; afterwards from the latch
  assign cur   = (state == IDLE) ? mReq : req;
  assign start = (state == IDLE) & mAcc & ~misal;

  dmem_align uAlign (
    .addrLo    (cur.addr[1:0]),
    .size      (cur.size),
    .sext      (cur.sext),
    .isWrite   (cur.we),
    .wd        (cur.wd),
    .rdRaw     (bus_rdata),
    .wdata     (fmtWdata),
    .wstrb     (fmtStrb),
    .rdFmt     (fmtRdata),
    .misaligned(misal)
  );

  // Next state and handshake outputs; IDLE-with-access and REQ share the branch
  always_comb begin
    stateNxt = state;
    busReqC  = 1'b0;
    stallC   = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    cntClr   = 1'b0;
    case (state)
      IDLE, REQ: begin
        if (state == REQ || start) begin
          busReqC = 1'b1;
          stallC  = 1'b1;
          if (bus_ready) begin
            if (cur.we) begin
              stateNxt = DONE;
            end else if (bus_rvalid) begin
              capture  = 1'b1;
              stateNxt = DONE;
            end else begin
              stateNxt = WAIT_R;
              cntClr   = 1'b1;
            end
          end else if (state == IDLE) begin
            stateNxt = REQ;
            cntClr   = 1'b1;
          end else if (cnt == TO_LAST) begin
            timeout  = 1'b1;
            stateNxt = DONE;
          end
        end
      end
      WAIT_R: begin
        stallC = 1'b1;
        if (bus_rvalid) begin
          capture  = 1'b1;
          stateNxt = DONE;
        end else if (cnt == TO_LAST) begin
          timeout  = 1'b1;
          stateNxt = DONE;
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  // Request latch: captured only on the IDLE cycle, so it is stable while waiting for ready
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)       req <= '0;
    else if (start) req <= mReq;
  end

  // Timeout counter: cleared entering REQ/WAIT_R, counts cycles spent there
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)                                   cnt <= '0;
    else if (cntClr)                            cnt <= '0;
    else if (state == REQ || state == WAIT_R)   cnt <= cnt + 1'b1;
  end

  // Load result register; zeroed at the start of each access and on timeout
  always_ff @(posedge clka or negedge rst) begin
    if (!rst)                    rdataQ <= '0;
    else if (capture)            rdataQ <= fmtRdata;
    else if (start || timeout)   rdataQ <= '0;
  end

  // bus_err is a one-cycle pulse coinciding with the DONE after a timeout
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) errQ <= 1'b0;
    else      errQ <= timeout;
  end

  assign bus_req   = busReqC;
  assign stallM    = stallC;
  assign bus_we    = busReqC & cur.we;
  assign bus_addr  = busReqC ? {cur.addr[31:2], 2'b00} : 32'd0;
  assign bus_wstrb = busReqC ? fmtStrb : 4'd0;
  assign bus_wdata = busReqC ? fmtWdata : 32'd0;
  assign mem_rdata = (state == DONE) ? rdataQ : 32'd0;
  assign bus_err   = errQ;
  assign adel      = (state == IDLE) & mAcc & misal & ~memwriteM;
  assign ades      = (state == IDLE) & mAcc & misal & memwriteM;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: the driver pushes expectations computed from
// the access rules, a negedge monitor pops and compares when the DUT responds.
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clka = 1'b0;
  logic        rst  = 1'b0;
  logic        memreadM, memwriteM, mem_signedM;
  logic [1:0]  mem_sizeM;
  logic [31:0] alu_resultM, writedataM;
  logic [31:0] mem_rdata;
  logic        stallM, adel, ades, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] addr; bit we; logic [3:0] strb; logic [31:0] wdata; } busExp_t;
  typedef struct { bit chkRd; logic [31:0] rdata; bit err; int stalls; } doneExp_t;
  typedef struct { bit adel; bit ades; } excExp_t;

  busExp_t  busQ[$];
  doneExp_t doneQ[$];
  excExp_t  excQ[$];
  busExp_t  be;
  doneExp_t de;
  excExp_t  xe;

  always #5 clka = ~clka;

  dmem_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clka(clka), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .mem_sizeM(mem_sizeM),
    .mem_signedM(mem_signedM), .alu_resultM(alu_resultM), .writedataM(writedataM),
    .mem_rdata(mem_rdata), .stallM(stallM), .adel(adel), .ades(ades), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- reference model: access rules as plain arithmetic ----
  function automatic bit misModel(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz >= 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ldModel(input logic [1:0] sz, input bit sg,
                                          input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (sg && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (w >> (8 * (a % 4))) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] strbModel(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] s;
    if (sz == 2'b00)      s = 32'd1 << (a % 4);
    else if (sz == 2'b01) s = 32'd3 << (a % 4);
    else                  s = 32'hF;
    return s[3:0];
  endfunction

  function automatic logic [31:0] wdModel(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic clearIn();
    memreadM = 0; memwriteM = 0; mem_sizeM = 0; mem_signedM = 0;
    alu_resultM = 0; writedataM = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic idleCycle();
    @(posedge clka); #1;
    clearIn();
  endtask

  // One M-stage access. r = cycles before bus_ready, d = cycles from ready to
  // rvalid (-1 = never). Expected latency follows from the timeout rules.
  task automatic doAccess(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int r, input int d);
    doneExp_t dx;
    busExp_t  bx;
    @(posedge clka); #1;
    memreadM = !we; memwriteM = we; mem_sizeM = sz; mem_signedM = sg;
    alu_resultM = a; writedataM = wd; bus_rdata = rd;
    if (misModel(sz, a)) begin
      bus_ready = 0; bus_rvalid = 0;
      excQ.push_back('{adel: !we, ades: we});
      @(negedge clka);
      return;
    end
    dx.chkRd = !we; dx.err = 0; dx.rdata = 0;
    if (r > TO) begin
      dx.err = 1; dx.stalls = TO + 1;
    end else if (we || d == 0) begin
      dx.stalls = r + 1;
    end else if (d < 0 || d > TO) begin
      dx.err = 1; dx.stalls = r + TO + 1;
    end else begin
      dx.stalls = r + d + 1;
    end
    if (!we && !dx.err) dx.rdata = ldModel(sz, sg, a, rd);
    if (r <= TO) begin
      bx.addr = a & 32'hFFFF_FFFC; bx.we = we;
      bx.strb = we ? strbModel(sz, a) : 4'b0000;
      bx.wdata = wdModel(sz, wd);
      busQ.push_back(bx);
    end
    doneQ.push_back(dx);
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin @(posedge clka); #1; end
      bus_ready  = (k == r);
      bus_rvalid = !we && d >= 0 && k == r + d;
      @(negedge clka);
      if (!stallM) return;
    end
    total++; bad++;
    $display("FAIL no_completion: got stallM stuck high expected release at %0d", a);
  endtask

  // ---- monitor: compare whenever the DUT presents a response ----
  int stallCnt  = 0;
  bit prevStall = 0;
  always @(negedge clka) begin
    if (!rst) begin
      stallCnt  = 0;
      prevStall = 0;
    end else begin
      if (bus_req && bus_ready) begin
        if (busQ.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: got request addr %h expected none", bus_addr);
        end else begin
          be = busQ.pop_front();
          chk("bus_addr", bus_addr, be.addr);
          chk("bus_we", 32'(bus_we), 32'(be.we));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(be.strb));
          if (be.we) chk("bus_wdata", bus_wdata, be.wdata);
        end
      end
      if (adel || ades) begin
        if (excQ.size() == 0) begin
          total++; bad++;
          $display("FAIL exc_unexpected: got adel=%0b ades=%0b expected none", adel, ades);
        end else begin
          xe = excQ.pop_front();
          chk("adel", 32'(adel), 32'(xe.adel));
          chk("ades", 32'(ades), 32'(xe.ades));
          chk("exc_bus_req", 32'(bus_req), 0);
          chk("exc_stallM", 32'(stallM), 0);
          chk("exc_rdata", mem_rdata, 0);
        end
      end
      if (stallM) begin
        stallCnt++;
      end else if (prevStall) begin
        if (doneQ.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got completion expected none");
        end else begin
          de = doneQ.pop_front();
          chk("stall_cycles", 32'(stallCnt), 32'(de.stalls));
          chk("bus_err", 32'(bus_err), 32'(de.err));
          if (de.chkRd) chk("mem_rdata", mem_rdata, de.rdata);
        end
        stallCnt = 0;
      end
      prevStall = stallM;
    end
  end

  bit          rWe, rSg;
  logic [1:0]  rSz;
  logic [31:0] rA, rWd, rRd;
  int          rR, rD;

  initial begin
    // reset with a live store on the M inputs: everything must stay 0
    memreadM = 0; memwriteM = 1; mem_sizeM = 2'b10; mem_signedM = 0;
    alu_resultM = 32'h100; writedataM = 32'hDEAD_BEEF;
    bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    #3;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_stallM", 32'(stallM), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_adel_ades", 32'({adel, ades}), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    clearIn();
    #19 rst = 1;

    // directed cases
    doAccess(1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, -1);
    doAccess(0, 2'b00, 1, 32'h103, 0, 32'h8012_3456, 2, 1);
    doAccess(0, 2'b00, 0, 32'h103, 0, 32'h8012_3456, 2, 1);
    doAccess(1, 2'b01, 0, 32'h202, 32'h0000_1234, 0, 0, -1);
    doAccess(0, 2'b01, 1, 32'h201, 0, 0, 0, 0);
    doAccess(1, 2'b10, 0, 32'h006, 32'h1111_2222, 0, 0, -1);
    doAccess(0, 2'b10, 0, 32'h300, 0, 32'h55AA_55AA, 0, -1);
    doAccess(0, 2'b01, 1, 32'h402, 0, 32'h9ABC_1234, 5, 0);
    idleCycle();

    // reset while in WAIT_R, then a stray rvalid must be ignored
    @(posedge clka); #1;
    memreadM = 1; memwriteM = 0; mem_sizeM = 2'b10; mem_signedM = 0;
    alu_resultM = 32'h40; bus_ready = 1; bus_rvalid = 0;
    busQ.push_back('{addr: 32'h40, we: 1'b0, strb: 4'b0000, wdata: 32'd0});
    @(posedge clka); #1;
    bus_ready = 0;
    @(negedge clka);
    chk("wait_r_stallM", 32'(stallM), 1);
    #2 rst = 0;
    #1;
    chk("arst_bus_req", 32'(bus_req), 0);
    chk("arst_stallM", 32'(stallM), 0);
    chk("arst_mem_rdata", mem_rdata, 0);
    clearIn();
    @(negedge clka);
    @(posedge clka); #1;
    rst = 1;
    bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clka);
    chk("late_rv_stallM", 32'(stallM), 0);
    chk("late_rv_bus_req", 32'(bus_req), 0);
    @(posedge clka); #1;
    bus_rvalid = 0;
    @(negedge clka);
    chk("late_rv_rdata", mem_rdata, 0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      rWe = 1'($urandom_range(0, 1));
      rSg = 1'($urandom_range(0, 1));
      rSz = 2'($urandom_range(0, 3));
      rA  = $urandom;
      if ($urandom_range(0, 2) != 0) rA = rA & (rSz == 2'b00 ? 32'hFFFF_FFFF :
                                                rSz == 2'b01 ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      rWd = $urandom;
      rRd = $urandom;
      rR  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 6)) : int'($urandom_range(0, 4));
      rD  = int'($urandom_range(0, 7)) - 1;
      doAccess(rWe, rSz, rSg, rA, rWd, rRd, rR, rD);
      if ($urandom_range(0, 1) != 0) idleCycle();
    end
    idleCycle();
    repeat (3) @(posedge clka);
    chk("busQ_drained", 32'(busQ.size()), 0);
    chk("doneQ_drained", 32'(doneQ.size()), 0);
    chk("excQ_drained", 32'(excQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
